// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment display driver.
//   SEG_BLANK  : all segments off (active-low pattern)
//   SEG_DASH   : only segment g lit, shown on every digit when the value overflows
//   SEG_TABLE  : active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
//   state_t    : conversion sequencer states
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n holds the pattern for digit n; the concatenation lists 9 first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Single-digit BCD to 7-segment decoder (purely combinational).
//   i_bcd : 4-bit BCD digit
//   o_seg : active-low segments {g,f,e,d,c,b,a}; codes above 9 give SEG_BLANK
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Look the digit up in the shared table; anything that is not a valid
  // decimal digit leaves the display dark rather than showing garbage.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_TABLE[i_bcd];
    end
  end

endmodule

// File: rtl/seg7_bin_disp.sv
// Multi-digit 7-segment display driver with sequential binary-to-BCD conversion.
//   CLK      : system clock, rising edge
//   RST      : asynchronous active-high reset
//   START    : one-cycle request, samples DIN and BLANK_EN when idle
//   DIN      : unsigned binary value to display
//   BLANK_EN : 1 = blank leading zeros
//   BUSY     : high while a conversion is in progress
//   DONE     : one-cycle pulse when nHEX/OVF are refreshed
//   OVF      : value did not fit in NDIGIT digits, held until next refresh
//   nHEX     : active-low segments, digit i at [7i+6:7i], digit 0 least significant
module seg7_bin_disp
  import seg7_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int NDIGIT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_W-1:0]     DIN,
  input  logic                  BLANK_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF,
  output logic [7*NDIGIT-1:0]   nHEX
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * NDIGIT;

  state_t               r_state;
  state_t               w_nextState;
  logic [DATA_W-1:0]    r_shReg;
  logic [BCD_W-1:0]     r_bcd;
  logic [BCD_W-1:0]     w_bcdAdj;
  logic [BCD_W-1:0]     w_bcdNext;
  logic                 w_ovfBit;
  logic                 r_blankEn;
  logic                 r_ovfSticky;
  logic [CNT_W-1:0]     r_cnt;
  logic [7*NDIGIT-1:0]  w_decSeg;
  logic [7*NDIGIT-1:0]  w_dispSeg;
  logic                 w_leadZero;
  logic [7*NDIGIT-1:0]  r_hex;
  logic                 r_ovf;
  logic                 r_done;

  // State register; an asynchronous reset aborts any conversion in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Sequencer: START is only honoured in IDLE, so requests while busy are
  // dropped. The counter is compared against DATA_W-1 because it reaches
  // DATA_W on the same edge that performs the last shift.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_nextState = CONV;
        end
      end
      CONV: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_nextState = UPDATE;
        end
      end
      UPDATE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Shift-and-add-3 step: correct every digit that would exceed 9 after
  // doubling, then shift the next binary bit into digit 0. A set bit 3 in
  // the corrected top digit means the value needs one more digit than we
  // have, so it is recorded as overflow.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < NDIGIT; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcdNext = {w_bcdAdj[BCD_W-2:0], r_shReg[DATA_W-1]};
    w_ovfBit  = w_bcdAdj[BCD_W-1];
  end

  // Conversion datapath: load on an accepted START, one bit per CONV cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shReg     <= '0;
      r_bcd       <= '0;
      r_blankEn   <= 1'b0;
      r_ovfSticky <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (r_state == IDLE && START) begin
        r_shReg     <= DIN;
        r_blankEn   <= BLANK_EN;
        r_bcd       <= '0;
        r_ovfSticky <= 1'b0;
        r_cnt       <= '0;
      end else if (r_state == CONV) begin
        r_shReg     <= r_shReg << 1;
        r_bcd       <= w_bcdNext;
        r_ovfSticky <= r_ovfSticky | w_ovfBit;
        r_cnt       <= r_cnt + 1'b1;
      end
    end
  end

  // One decoder per digit.
  for (genvar g = 0; g < NDIGIT; g++) begin : g_dec
    seg7_digit_dec u_dec (
      .i_bcd (r_bcd[4*g +: 4]),
      .o_seg (w_decSeg[7*g +: 7])
    );
  end

  // Leading-zero blanking: walk down from the top digit and darken zeros
  // until the first nonzero digit. Digit 0 is never blanked so that a value
  // of zero still shows "0".
  always_comb begin
    w_dispSeg  = w_decSeg;
    w_leadZero = r_blankEn;
    for (int i = NDIGIT - 1; i >= 1; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        w_leadZero = 1'b0;
      end
      if (w_leadZero) begin
        w_dispSeg[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  // Output registers only change on the UPDATE edge, so the display holds
  // the last result between conversions. Overflow replaces every digit with
  // a dash regardless of blanking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hex  <= {NDIGIT{SEG_BLANK}};
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == UPDATE) begin
        r_ovf  <= r_ovfSticky;
        r_hex  <= r_ovfSticky ? {NDIGIT{SEG_DASH}} : w_dispSeg;
        r_done <= 1'b1;
      end
    end
  end

  assign BUSY = (r_state != IDLE);
  assign DONE = r_done;
  assign OVF  = r_ovf;
  assign nHEX = r_hex;

endmodule
